// File: rtl/flanger_delay.sv
// Multi-channel flanger: on-chip circular delay line per channel, triangle-LFO swept tap,
// output is the signed average of the dry and delayed samples (or dry only in bypass).
module flanger_delay #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 256,
  parameter int MIN_DLY  = 8,
  parameter int MAX_DLY  = 200,
  parameter int RATE_DIV = 64
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         flanger_en,
  input  logic                         shift_en,
  input  logic [NUM_CH*DATA_W-1:0]     input_data,
  output logic [NUM_CH*DATA_W-1:0]     output_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH)-1:0]     cur_dly
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = NUM_CH * DATA_W;
  localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [RW-1:0] RATE_LAST = RW'(RATE_DIV - 1);
  localparam logic [AW-1:0] FILL_MAX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DLY_MIN   = AW'(MIN_DLY);
  localparam logic [AW-1:0] DLY_MAX   = AW'(MAX_DLY);

  typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    in_reg;
  logic [W-1:0]    dly_reg;
  logic [W-1:0]    mix_data;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   fill;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   dly_step;
  logic            dir_up;
  logic [RW-1:0]   rate_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_en) state_nxt = READ;
      READ:    state_nxt = MIX;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign rd_addr  = wptr - cur_dly;
  assign dly_step = dir_up ? (cur_dly + AW'(1)) : (cur_dly - AW'(1));

  // Sum in DATA_W+1 bits so the halving never overflows; the shift floors toward -inf.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_mix
    logic [DATA_W:0] sum;
    assign sum = {in_reg[c*DATA_W + DATA_W - 1], in_reg[c*DATA_W +: DATA_W]}
               + {dly_reg[c*DATA_W + DATA_W - 1], dly_reg[c*DATA_W +: DATA_W]};
    assign mix_data[c*DATA_W +: DATA_W] = DATA_W'(sum >> 1);
  end

  // Delay-line storage is deliberately unreset; the fill counter hides stale entries.
  always_ff @(posedge clk) begin
    if (state == MIX) mem[wptr] <= in_reg;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_reg      <= '0;
      dly_reg     <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      wptr        <= '0;
      fill        <= '0;
      cur_dly     <= DLY_MIN;
      dir_up      <= 1'b1;
      rate_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (shift_en) in_reg <= input_data;
        end
        READ: begin
          dly_reg <= (fill < cur_dly) ? '0 : mem[rd_addr];
        end
        MIX: begin
          output_data <= flanger_en ? mix_data : in_reg;
          out_valid   <= 1'b1;
          wptr        <= wptr + AW'(1);
          if (fill != FILL_MAX) fill <= fill + AW'(1);
          // LFO advances only on processed samples; bypass freezes the sweep position.
          if (flanger_en) begin
            if (rate_cnt == RATE_LAST) begin
              rate_cnt <= '0;
              cur_dly  <= dly_step;
              if (dir_up && dly_step == DLY_MAX)  dir_up <= 1'b0;
              if (!dir_up && dly_step == DLY_MIN) dir_up <= 1'b1;
            end else begin
              rate_cnt <= rate_cnt + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flanger_delay.sv
// Scoreboard bench for flanger_delay: a reference model predicts each output when the
// strobe is driven; the monitor pops and compares whenever out_valid pulses.
module tb_flanger_delay;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 2;
  localparam int DEPTH    = 16;
  localparam int MIN_DLY  = 2;
  localparam int MAX_DLY  = 4;
  localparam int RATE_DIV = 2;
  localparam int W        = NUM_CH * DATA_W;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          flanger_en;
  logic          shift_en;
  logic [W-1:0]  input_data;
  logic [W-1:0]  output_data;
  logic          out_valid;
  logic          busy;
  logic [3:0]    cur_dly;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   dly;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_vec  = 0;
  int            n_fail = 0;

  logic [W-1:0]  m_buf [DEPTH];
  int            m_wptr, m_fill, m_dly, m_rate;
  bit            m_up;

  flanger_delay #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
    .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .RATE_DIV(RATE_DIV)
  ) dut (
    .clk(clk), .n_rst(n_rst), .flanger_en(flanger_en), .shift_en(shift_en),
    .input_data(input_data), .output_data(output_data), .out_valid(out_valid),
    .busy(busy), .cur_dly(cur_dly)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    m_wptr = 0;
    m_fill = 0;
    m_dly  = MIN_DLY;
    m_up   = 1'b1;
    m_rate = 0;
  endtask

  task automatic model_push(input logic [W-1:0] d, input logic en);
    logic [W-1:0] o;
    int x, y, idx;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      x   = sx(d[ch*DATA_W +: DATA_W]);
      idx = (m_wptr - m_dly) & (DEPTH - 1);
      y   = (m_fill < m_dly) ? 0 : sx(m_buf[idx][ch*DATA_W +: DATA_W]);
      o[ch*DATA_W +: DATA_W] = en ? 16'((x + y) >>> 1) : d[ch*DATA_W +: DATA_W];
    end
    m_buf[m_wptr] = d;
    m_wptr = (m_wptr + 1) % DEPTH;
    if (m_fill < DEPTH - 1) m_fill++;
    if (en) begin
      if (m_rate == RATE_DIV - 1) begin
        m_rate = 0;
        if (m_up) begin
          m_dly++;
          if (m_dly == MAX_DLY) m_up = 1'b0;
        end else begin
          m_dly--;
          if (m_dly == MIN_DLY) m_up = 1'b1;
        end
      end else begin
        m_rate++;
      end
    end
    exp_q.push_back('{data: o, dly: 4'(m_dly)});
  endtask

  // One sample with full latency check: busy after k and k+1, out_valid only after k+2.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic en);
    @(negedge clk);
    flanger_en = en;
    input_data = d;
    shift_en   = 1'b1;
    model_push(d, en);
    @(negedge clk);
    shift_en = 1'b0;
    check_output("busy_k", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_output("busy_k1", {31'b0, busy}, 32'd1);
    check_output("early_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check_output("valid_k2", {31'b0, out_valid}, 32'd1);
    check_output("idle_k2", {31'b0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (n_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("data", output_data, mon_e.data);
        check_output("cur_dly", {28'b0, cur_dly}, {28'b0, mon_e.dly});
      end
    end
  end

  initial begin
    n_rst      = 1'b0;
    shift_en   = 1'b0;
    flanger_en = 1'b1;
    input_data = '0;
    model_reset();
    #23;
    check_output("rst_data", output_data, 32'd0);
    check_output("rst_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_dly", {28'b0, cur_dly}, MIN_DLY);
    @(negedge clk);
    n_rst = 1'b1;

    // Empty delay line: tap forced to zero, -3 floors to -2.
    apply_stimulus({16'd100, 16'hFFFD}, 1'b1);
    apply_stimulus({16'hFEDC, 16'h1234}, 1'b0);

    // Ramp long enough to wrap the write pointer and sweep the LFO both ways.
    for (int n = 0; n < 40; n++)
      apply_stimulus({16'(10 * n + 5), 16'(-10 * n)}, 1'b1);

    // Second strobe while busy must be dropped; strobe at k+3 is accepted.
    @(negedge clk);
    flanger_en = 1'b1;
    input_data = 32'h0111_0222;
    shift_en   = 1'b1;
    model_push(32'h0111_0222, 1'b1);
    @(negedge clk);
    input_data = 32'h7777_7777;
    @(negedge clk);
    shift_en = 1'b0;
    check_output("drop_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_output("drop_valid", {31'b0, out_valid}, 32'd1);
    input_data = 32'h0333_0444;
    shift_en   = 1'b1;
    model_push(32'h0333_0444, 1'b1);
    @(negedge clk);
    shift_en = 1'b0;
    check_output("k3_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_output("k3_valid", {31'b0, out_valid}, 32'd1);

    // Bypass run keeps writing history; enabled samples then tap into it.
    for (int n = 0; n < 20; n++)
      apply_stimulus(W'($urandom), 1'b0);
    for (int n = 0; n < 8; n++)
      apply_stimulus(W'($urandom), 1'b1);

    // Reset while in READ aborts the sample.
    @(negedge clk);
    input_data = 32'h5555_AAAA;
    shift_en   = 1'b1;
    @(negedge clk);
    shift_en = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    check_output("abort_data", output_data, 32'd0);
    check_output("abort_valid", {31'b0, out_valid}, 32'd0);
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_dly", {28'b0, cur_dly}, MIN_DLY);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    for (int n = 0; n < 6; n++)
      apply_stimulus(W'($urandom), 1'b1);

    repeat (5) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/flanger_delay.md
Name: flanger_delay

Overview:
- Next-generation multi-channel flanger with its own on-chip circular delay line; no external SRAM handshake.
- A triangle LFO sweeps the tap delay between MIN_DLY and MAX_DLY. Each output is the signed average of the dry sample and the delayed sample.
- Sits between the audio input deserialiser and the output shifter. Runs once per `shift_en` sample strobe.

Parameters:
- DATA_W, 16: signed sample width per channel.
- NUM_CH, 2: channels, packed; channel 0 in the LSBs.
- DEPTH, 256: delay-line entries per channel. Power of two, at least 4.
- MIN_DLY, 8: minimum tap delay in samples. Must be at least 1.
- MAX_DLY, 200: maximum tap delay in samples. MIN_DLY < MAX_DLY ≤ DEPTH-1.
- RATE_DIV, 64: accepted enabled samples per LFO step. Must be at least 1.

Ports:
- `clk`, in, 1: system clock.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `flanger_en`, in, 1: 1 = effect on; 0 = bypass.
- `shift_en`, in, 1: new-sample strobe, 1 cycle wide.
- `input_data`, in, NUM_CH*DATA_W: dry samples.
- `output_data`, out, NUM_CH*DATA_W: processed samples, registered.
- `out_valid`, out, 1: 1-cycle pulse when `output_data` updates.
- `busy`, out, 1: high while the FSM is not in IDLE.
- `cur_dly`, out, clog2(DEPTH): current tap delay, for debug.

Behaviour:
- Reset values (asynchronous, while `n_rst`=0):
  - state=IDLE; `output_data`=0, `out_valid`=0, `busy`=0.
  - wptr=0, fill=0, `cur_dly`=MIN_DLY, LFO direction=up, rate counter=0.
  - Delay-line RAM contents are not reset; the fill counter masks them.
- FSM states are IDLE, READ and MIX.
  - IDLE: if `shift_en`=1, capture `input_data` into in_reg and go to READ. Otherwise stay.
  - READ: for every channel, dly_reg ← buf[(wptr − `cur_dly`) mod DEPTH]. If fill < `cur_dly`, dly_reg ← 0 instead. Go to MIX.
  - MIX: sample `flanger_en`. Update `output_data`, pulse `out_valid`, write buf[wptr] ← in_reg, then wptr ← wptr+1 (wraps DEPTH-1→0). Increment fill, saturating at DEPTH-1. Go to IDLE.
- Latency:
  - `shift_en` seen at edge k → `output_data`/`out_valid` valid after edge k+2.
  - Throughput is 1 sample per 3 cycles.
  - `busy`=1 after edges k and k+1.
- `shift_en` while `busy`=1 is ignored: the sample is dropped and no state changes.
- Mix, per channel, signed: out = (x + y) >>> 1.
  - Computed in DATA_W+1 bits, then arithmetic shift (rounds toward −inf).
  - The result always fits; no saturation is needed.
- Bypass (`flanger_en`=0 at MIX):
  - `output_data` ← in_reg with the same 2-cycle latency; `out_valid` pulses as normal.
  - The delay line is still written and wptr/fill still advance, so history is intact on re-enable.
  - LFO and rate counter hold.
- LFO runs only on MIX cycles with `flanger_en`=1:
  - The rate counter increments. When it reaches RATE_DIV-1 it clears and `cur_dly` steps ±1.
  - Direction flips after the step that reaches MAX_DLY (now down) or MIN_DLY (now up).
  - `cur_dly` always stays within [MIN_DLY, MAX_DLY]; endpoints are held for exactly one step period.
- The tap uses the `cur_dly` value before this MIX's LFO update.
- Toggling `flanger_en` mid-operation has effect only at MIX. No glitch on `output_data` outside `out_valid` updates.
- Reset during READ or MIX aborts the sample: no write and no `out_valid`.

Test Plan:
- Reset: assert `n_rst`=0 mid-READ → all outputs 0, `cur_dly`=MIN_DLY, `busy`=0. First later strobe outputs x/2, with no X from the RAM.
- Bypass: `flanger_en`=0, input 0x1234/0xFEDC → `output_data`=0xFEDC_1234 exactly 2 cycles after `shift_en`, single `out_valid` pulse, `cur_dly` unchanged.
- Empty line / rounding, MIN_DLY=8: first sample ch0=−3, ch1=100 → outputs −2 and 50, since the delayed tap is forced to 0.
- Tap, with DEPTH=16, MIN_DLY=2, MAX_DLY=4, RATE_DIV=1:
  - Input a ramp 0,10,20,…; sample n outputs (10n + 10(n−d))>>>1.
  - d sequence from sample 0: 2,3,4,3,2,3…
  - wptr wraps after 16 samples with no discontinuity.
- Busy drop: `shift_en` at cycles k and k+1 → exactly one `out_valid` and wptr advances by 1. `shift_en` at k+3 is accepted.
- Re-enable: 20 bypassed samples, then `flanger_en`=1 → the first enabled output mixes with the sample written `cur_dly` samples earlier during bypass.
